// File: rtl/sha256_core_arbiter_if.sv
// rtl/sha256_core_arbiter_if.sv - requester/core handshake bundle for the SHA-256 core arbiter
// slave is the arbiter side; master is the requester-and-core side.
interface sha256_core_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int OW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] req_i;
  logic [NUM_REQ-1:0] last_i;
  logic [NUM_REQ-1:0] ack_o;
  logic [NUM_REQ-1:0] grant_o;
  logic [OW-1:0]      owner_o;
  logic               busy_o;
  logic               core_start_o;
  logic               core_done_i;
  logic               core_abort_o;
  logic [NUM_REQ-1:0] blk_done_o;
  logic               err_o;

  modport slave (
    input  req_i, last_i, core_done_i,
    output ack_o, grant_o, owner_o, busy_o, core_start_o, core_abort_o, blk_done_o, err_o
  );

  modport master (
    output req_i, last_i, core_done_i,
    input  ack_o, grant_o, owner_o, busy_o, core_start_o, core_abort_o, blk_done_o, err_o
  );
endinterface

// File: rtl/sha256_core_arbiter.sv
// rtl/sha256_core_arbiter.sv - round-robin owner arbiter and block sequencer for a shared SHA-256 core
// Ownership is held per message; a watchdog releases a stalled core or an absent owner.
module sha256_core_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  sha256_core_arbiter_if.slave    bus
);
  localparam int OW = $clog2(NUM_REQ);
  localparam int WW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, START, WAIT, HOLD} state_t;

  state_t             state_q;
  logic [OW-1:0]      owner_q;
  logic [OW-1:0]      rr_q;
  logic               last_q;
  logic [WW-1:0]      wdog_q;
  logic [NUM_REQ-1:0] grant_q;
  logic               busy_q;
  logic               start_q;

  logic               win_found;
  logic [OW-1:0]      win_idx;
  logic [OW-1:0]      rr_d;
  logic               wdog_max;
  logic [NUM_REQ-1:0] ack_d;
  logic [NUM_REQ-1:0] blk_done_d;
  logic               err_d;
  logic               abort_d;

  // First requester at or above rr_q, wrapping
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      int            j;
      logic [OW-1:0] cand;
      j = int'(rr_q) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      cand = OW'(j);
      if (!win_found && bus.req_i[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign rr_d     = (owner_q == OW'(NUM_REQ - 1)) ? '0 : owner_q + OW'(1);
  assign wdog_max = (wdog_q == WW'(TIMEOUT - 1));

  always_comb begin
    ack_d      = '0;
    blk_done_d = '0;
    err_d      = 1'b0;
    abort_d    = 1'b0;
    case (state_q)
      IDLE: if (win_found) ack_d[win_idx] = 1'b1;
      WAIT: begin
        if (bus.core_done_i) begin
          blk_done_d[owner_q] = 1'b1;
        end else if (wdog_max) begin
          err_d   = 1'b1;
          abort_d = 1'b1;
        end
      end
      HOLD: begin
        if (bus.req_i[owner_q]) ack_d[owner_q] = 1'b1;
        else if (wdog_max)      err_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      rr_q    <= '0;
      last_q  <= 1'b0;
      wdog_q  <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_found) begin
            state_q <= START;
            owner_q <= win_idx;
            last_q  <= bus.last_i[win_idx];
            grant_q <= NUM_REQ'(1) << win_idx;
            busy_q  <= 1'b1;
            start_q <= 1'b1;
          end
        end
        START: begin
          state_q <= WAIT;
          wdog_q  <= '0;
          start_q <= 1'b0;
        end
        WAIT: begin
          if (bus.core_done_i) begin
            if (last_q) begin
              rr_q    <= rr_d;
              state_q <= IDLE;
              grant_q <= '0;
              busy_q  <= 1'b0;
            end else begin
              wdog_q  <= '0;
              state_q <= HOLD;
            end
          end else if (wdog_max) begin
            rr_q    <= rr_d;
            state_q <= IDLE;
            grant_q <= '0;
            busy_q  <= 1'b0;
          end else begin
            wdog_q <= wdog_q + WW'(1);
          end
        end
        HOLD: begin
          if (bus.req_i[owner_q]) begin
            last_q  <= bus.last_i[owner_q];
            state_q <= START;
            start_q <= 1'b1;
          end else if (wdog_max) begin
            rr_q    <= rr_d;
            state_q <= IDLE;
            grant_q <= '0;
            busy_q  <= 1'b0;
          end else begin
            wdog_q <= wdog_q + WW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
          busy_q  <= 1'b0;
          start_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ack_o        = ack_d;
  assign bus.blk_done_o   = blk_done_d;
  assign bus.err_o        = err_d;
  assign bus.core_abort_o = abort_d;
  assign bus.grant_o      = grant_q;
  assign bus.owner_o      = owner_q;
  assign bus.busy_o       = busy_q;
  assign bus.core_start_o = start_q;
endmodule

// File: tb/tb_sha256_core_arbiter.sv
// tb/tb_sha256_core_arbiter.sv - scoreboard bench for sha256_core_arbiter (NUM_REQ=4, TIMEOUT=70)
// Stimulus pushes timestamped expected events; the negedge monitor pops and compares them.
module tb_sha256_core_arbiter;
  localparam int TMO = 70;
  localparam int K_IDLE = 0, K_ACK = 1, K_START = 2, K_DONE = 3, K_ERR = 4;

  typedef struct {
    int         kind;
    int         cyc;
    logic [7:0] val;
  } ev_t;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic busy_prev = 1'b0;
  ev_t  exp_q[$];
  int   t;

  sha256_core_arbiter_if #(.NUM_REQ(4)) bus ();

  sha256_core_arbiter #(.NUM_REQ(4), .TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      K_IDLE:  return "idle";
      K_ACK:   return "ack";
      K_START: return "start";
      K_DONE:  return "blk_done";
      default: return "err";
    endcase
  endfunction

  task automatic expect_ev(input int kind, input int c, input logic [7:0] val);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic got(input int kind, input logic [7:0] val);
    int idx;
    idx = -1;
    checks++;
    for (int i = 0; i < exp_q.size(); i++)
      if (idx < 0 && exp_q[i].kind == kind) idx = i;
    if (idx < 0) begin
      errors++;
      $display("FAIL unexpected_%s: cycle %0d got %h, expected no event", kname(kind), cyc, val);
    end else begin
      if (exp_q[idx].cyc != cyc || exp_q[idx].val != val) begin
        errors++;
        $display("FAIL %s: got cycle %0d val %h, expected cycle %0d val %h",
                 kname(kind), cyc, val, exp_q[idx].cyc, exp_q[idx].val);
      end
      exp_q.delete(idx);
    end
  endtask

  // err event value: {err, abort} in bits 5:4, owner in bits 1:0
  always @(negedge clk) begin
    if (busy_prev && !bus.busy_o)        got(K_IDLE, {4'b0, bus.grant_o});
    if (bus.ack_o != 4'b0)               got(K_ACK, {4'b0, bus.ack_o});
    if (bus.core_start_o)                got(K_START, {4'b0, bus.grant_o});
    if (bus.blk_done_o != 4'b0)          got(K_DONE, {4'b0, bus.blk_done_o});
    if (bus.err_o || bus.core_abort_o)   got(K_ERR, {2'b0, bus.err_o, bus.core_abort_o, 2'b0, bus.owner_o});
    busy_prev = bus.busy_o;
  end

  task automatic at(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_done(input int c);
    at(c);
    bus.core_done_i = 1'b1;
    at(c + 1);
    bus.core_done_i = 1'b0;
  endtask

  task automatic check_quiet(input string name);
    logic [20:0] outs;
    outs = {bus.ack_o, bus.grant_o, bus.owner_o, bus.busy_o, bus.core_start_o,
            bus.core_abort_o, bus.blk_done_o, bus.err_o};
    checks++;
    if (outs != 21'b0) begin
      errors++;
      $display("FAIL %s: outputs %h, expected all zero", name, outs);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.req_i = 4'b0;
    bus.last_i = 4'b0;
    bus.core_done_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset_state");
    rst = 1'b0;

    // done outside WAIT is ignored
    pulse_done(cyc + 1);

    // fairness: all four requesting, single-block messages
    t = cyc + 2;
    at(t);
    bus.req_i = 4'b1111;
    bus.last_i = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      int a;
      a = t + 4 * k;
      expect_ev(K_ACK, a, 8'(1 << (k % 4)));
      expect_ev(K_START, a + 1, 8'(1 << (k % 4)));
      expect_ev(K_DONE, a + 3, 8'(1 << (k % 4)));
      expect_ev(K_IDLE, a + 4, 8'h0);
      if (k == 4) begin
        at(a + 1);
        bus.req_i = 4'b0;
      end
      pulse_done(a + 3);
    end

    // single block, 66-cycle core latency
    t = cyc + 2;
    at(t);
    bus.req_i = 4'b0100;
    bus.last_i = 4'b0100;
    expect_ev(K_ACK, t, 8'h4);
    expect_ev(K_START, t + 1, 8'h4);
    expect_ev(K_DONE, t + 67, 8'h4);
    expect_ev(K_IDLE, t + 68, 8'h0);
    at(t + 1);
    bus.req_i = 4'b0;
    pulse_done(t + 67);

    // pointer wrap from 3
    t = cyc;
    bus.req_i = 4'b1001;
    bus.last_i = 4'b1001;
    expect_ev(K_ACK, t, 8'h8);
    expect_ev(K_START, t + 1, 8'h8);
    expect_ev(K_DONE, t + 4, 8'h8);
    expect_ev(K_IDLE, t + 5, 8'h0);
    expect_ev(K_ACK, t + 5, 8'h1);
    expect_ev(K_START, t + 6, 8'h1);
    expect_ev(K_DONE, t + 9, 8'h1);
    expect_ev(K_IDLE, t + 10, 8'h0);
    at(t + 1);
    bus.req_i = 4'b0001;
    pulse_done(t + 4);
    at(t + 6);
    bus.req_i = 4'b0;
    pulse_done(t + 9);

    // multi-block lock: requester 1 sends 3 blocks while requester 2 waits
    t = cyc;
    bus.req_i = 4'b0110;
    bus.last_i = 4'b0000;
    for (int b = 0; b < 3; b++) begin
      expect_ev(K_ACK, t + 5 * b, 8'h2);
      expect_ev(K_START, t + 5 * b + 1, 8'h2);
      expect_ev(K_DONE, t + 5 * b + 4, 8'h2);
    end
    expect_ev(K_IDLE, t + 15, 8'h0);
    expect_ev(K_ACK, t + 15, 8'h4);
    expect_ev(K_START, t + 16, 8'h4);
    expect_ev(K_DONE, t + 19, 8'h4);
    expect_ev(K_IDLE, t + 20, 8'h0);
    pulse_done(t + 4);
    pulse_done(t + 9);
    at(t + 10);
    bus.last_i = 4'b0110;
    at(t + 11);
    bus.req_i = 4'b0100;
    pulse_done(t + 14);
    at(t + 16);
    bus.req_i = 4'b0;
    pulse_done(t + 19);

    // WAIT timeout: no done ever
    t = cyc;
    bus.req_i = 4'b0001;
    bus.last_i = 4'b0001;
    expect_ev(K_ACK, t, 8'h1);
    expect_ev(K_START, t + 1, 8'h1);
    expect_ev(K_ERR, t + 1 + TMO, 8'h30);
    expect_ev(K_IDLE, t + 2 + TMO, 8'h0);
    at(t + 1);
    bus.req_i = 4'b0;
    at(t + 2 + TMO);

    // done coincides with the last watchdog cycle: done wins
    t = cyc;
    bus.req_i = 4'b0010;
    bus.last_i = 4'b0010;
    expect_ev(K_ACK, t, 8'h2);
    expect_ev(K_START, t + 1, 8'h2);
    expect_ev(K_DONE, t + 1 + TMO, 8'h2);
    expect_ev(K_IDLE, t + 2 + TMO, 8'h0);
    at(t + 1);
    bus.req_i = 4'b0;
    pulse_done(t + 1 + TMO);

    // HOLD timeout: owner never offers its next block
    t = cyc;
    bus.req_i = 4'b0100;
    bus.last_i = 4'b0000;
    expect_ev(K_ACK, t, 8'h4);
    expect_ev(K_START, t + 1, 8'h4);
    expect_ev(K_DONE, t + 4, 8'h4);
    expect_ev(K_ERR, t + 4 + TMO, 8'h22);
    expect_ev(K_IDLE, t + 5 + TMO, 8'h0);
    at(t + 1);
    bus.req_i = 4'b0;
    pulse_done(t + 4);
    at(t + 5 + TMO);

    // reset during WAIT
    t = cyc;
    bus.req_i = 4'b1000;
    bus.last_i = 4'b1000;
    expect_ev(K_ACK, t, 8'h8);
    expect_ev(K_START, t + 1, 8'h8);
    expect_ev(K_IDLE, t + 3, 8'h0);
    at(t + 1);
    bus.req_i = 4'b0;
    at(t + 3);
    rst = 1'b1;
    #1;
    check_quiet("reset_in_wait");
    at(t + 4);
    rst = 1'b0;

    // pointer back at 0 after reset: 1 wins over 3
    t = cyc + 1;
    at(t);
    bus.req_i = 4'b1010;
    bus.last_i = 4'b1010;
    expect_ev(K_ACK, t, 8'h2);
    expect_ev(K_START, t + 1, 8'h2);
    expect_ev(K_DONE, t + 3, 8'h2);
    expect_ev(K_IDLE, t + 4, 8'h0);
    at(t + 1);
    bus.req_i = 4'b0;
    pulse_done(t + 3);
    at(t + 6);

    while (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL missing_%s: got no event, expected cycle %0d val %h",
               kname(exp_q[0].kind), exp_q[0].cyc, exp_q[0].val);
      void'(exp_q.pop_front());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sha256_core_arbiter.md
# sha256_core_arbiter

Round-robin arbiter and sequencer that shares one SHA-256 hash core among NUM_REQ requesters. Each requester may own the core for a multi-block message.
- Grants the core to one requester.
- Issues a start pulse per 512-bit block and returns a per-requester block-done pulse.
- Keeps ownership locked until the requester's last block completes.
- Recovers from a stalled core or an absent requester through a watchdog.

Sits between the requester front-ends and the core's controller start/done interface.

## Interface
- NUM_REQ, 4: number of requesters, 2..16.
- TIMEOUT, 256: watchdog limit in cycles, ≥ 2; must exceed the core's block latency.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_i  in  NUM_REQ  per-requester "block ready" level.
- last_i  in  NUM_REQ  marks the offered block as the final block of its message; sampled only with ack.
- ack_o  out  NUM_REQ  one-hot, one-cycle accept of a block (combinational).
- grant_o  out  NUM_REQ  one-hot core ownership (selects the block-data mux).
- owner_o  out  $clog2(NUM_REQ)  index of the current owner.
- busy_o  out  1  high in any state other than IDLE.
- core_start_o  out  1  one-cycle start pulse to the core.
- core_done_i  in  1  one-cycle pulse from the core when its block completes.
- core_abort_o  out  1  one-cycle flush pulse to the core on a WAIT timeout.
- blk_done_o  out  NUM_REQ  one-hot, one-cycle block completion (combinational).
- err_o  out  1  one-cycle watchdog error; owner_o is valid in the same cycle.

## Operation
- The FSM has four states: IDLE, START, WAIT, HOLD. Registers are state, owner, rr_ptr, last_q and wdog.

IDLE
- If any req_i is set, the winner is the first set bit searched from rr_ptr upward, wrapping modulo NUM_REQ.
- ack_o[winner] = 1. owner <= winner. last_q <= last_i[winner]. Next state is START.

START
- core_start_o = 1. wdog <= 0. Next state is WAIT.

WAIT
- wdog increments each cycle.
- On core_done_i: blk_done_o[owner] = 1 in that cycle.
  - If last_q = 1: rr_ptr <= (owner+1) mod NUM_REQ and the next state is IDLE.
  - Otherwise wdog <= 0 and the next state is HOLD.
- Else if wdog == TIMEOUT-1: err_o = 1, core_abort_o = 1, rr_ptr advances as above, next state is IDLE.

HOLD
- Ownership stays locked; all other requests are ignored.
- If req_i[owner] = 1: ack_o[owner] = 1, last_q <= last_i[owner], next state is START.
- Else wdog increments. At wdog == TIMEOUT-1: err_o = 1, rr_ptr advances, next state is IDLE. core_abort_o is not asserted in HOLD.

Outputs and state details
- grant_o[owner] = 1 in START, WAIT and HOLD; otherwise grant_o is 0.
- core_done_i is ignored outside WAIT.
- Illegal state encodings return to IDLE with all outputs 0.
- Requester rules:
  - Block data and last_i must be stable from ack through the matching blk_done_o.
  - req_i may stay high, or go high again any time after ack, to offer the next block; only HOLD consumes it.
- wdog is $clog2(TIMEOUT) bits wide and never wraps, because its compare exits the state first.

## Timing
- Reset: the state returns to IDLE immediately. All outputs are 0, including owner_o = 0 and grant_o = 0. rr_ptr = 0, last_q = 0, wdog = 0.
- Reset mid-operation drops the grant asynchronously. No done or error pulse is produced.
- Accept at cycle t (ack). START at t+1 (core_start_o, grant_o). WAIT from t+2.
- With the core done L cycles after start: blk_done_o fires at t+1+L, and the arbiter is back in IDLE, or in HOLD, at t+2+L.
- Back-to-back messages: the earliest next accept is at t+2+L. One idle-arbitration cycle is the minimum gap.
- Next block in a locked message: if req_i[owner] is already high when HOLD is entered, ack comes the first HOLD cycle and START the cycle after.
- core_done_i and wdog == TIMEOUT-1 in the same cycle: done wins and no error is raised.
- A WAIT timeout fires TIMEOUT cycles after the START cycle.
- Fairness: each requester is granted at most once per rotation among active requesters. This holds per message, not per block.

## Test plan
- Single block, NUM_REQ=4:
  - Stimulus: req_i=0b0100 with last=1 at cycle 10; core done 66 cycles after start.
  - Required: ack_o=0b0100 at 10, core_start at 11, blk_done_o=0b0100 at 77, busy_o low at 78, rr_ptr=3.
- Fairness:
  - Stimulus: req_i=0b1111 held continuously, every block last=1.
  - Required: grant order is 0,1,2,3,0, and no requester is granted twice before every active requester has been granted once.
- Multi-block lock:
  - Stimulus: requester 1 sends 3 blocks (last on the 3rd) while requester 2 requests throughout.
  - Required: three core_start pulses are all under grant_o=0b0010; requester 2 is acked only after the 3rd blk_done.
- Pointer wrap:
  - Stimulus: rr_ptr=3, req_i=0b1001.
  - Required: requester 3 is granted first, then requester 0.
- WAIT timeout:
  - Stimulus: TIMEOUT=8, and core_done_i is never sent.
  - Required: err_o and core_abort_o fire 8 cycles after the start cycle, then the state is IDLE and the grant is released.
  - Also: done and timeout in the same cycle give blk_done_o and no err_o.
- HOLD timeout and reset:
  - Stimulus: the owner's non-last block completes and the owner never re-requests.
  - Required: err_o fires after TIMEOUT cycles, with no core_abort_o. Asserting rst during WAIT zeroes all outputs immediately.
